// File: rtl/action_seq_pkg.sv
// Shared action codes and sequencer state encodings.
// Also consumed by the downstream two-digit display coder.
package action_seq_pkg;

  localparam logic [2:0] ACT_DN      = 3'b000;
  localparam logic [2:0] ACT_A1      = 3'b001;
  localparam logic [2:0] ACT_UP      = 3'b010;
  localparam logic [2:0] ACT_A2      = 3'b011;
  localparam logic [2:0] ACT_R1      = 3'b100;
  localparam logic [2:0] ACT_R2      = 3'b101;
  localparam logic [2:0] ACT_NOTHING = 3'b110;

  localparam int NUM_STEPS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } seq_state_e;

endpackage

// File: rtl/action_sequencer_dwell_timer.sv
// Dwell timer: counts 0..DWELL-1 while enabled, pulses o_tc
// on the last cycle and wraps to zero; i_clr forces zero.
module dwell_timer #(
  parameter int DWELL = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] r_cnt;

  assign o_tc = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tc) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/action_sequencer.sv
// Action sequencer: plays a 4-step program, each step held DWELL cycles.
// Define ACTION_REPEAT_EN to loop the program until stop/reset.
module action_sequencer
  import action_seq_pkg::*;
#(
  parameter int DWELL = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       stop,
  input  logic       prog,
  output logic [2:0] action,
  output logic       busy,
  output logic       done
);

  seq_state_e r_state;
  seq_state_e w_state_nxt;
  logic [1:0] r_step;
  logic [1:0] w_step_nxt;
  logic       r_prog;
  logic       w_prog_nxt;
  logic       r_done;
  logic       w_done_nxt;
  logic       w_tc;
  logic       w_run;

  assign w_run = (r_state == ST_RUN);

  dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_run),
    .i_clr (!w_run),
    .o_tc  (w_tc)
  );

  function automatic logic [2:0] step_code(
    input logic       p,
    input logic [1:0] s
  );
    logic [2:0] c;
    c = ACT_DN;
    unique case (s)
      2'd0:    c = ACT_UP;
      2'd1:    c = p ? ACT_A2 : ACT_A1;
      2'd2:    c = p ? ACT_R2 : ACT_R1;
      default: c = ACT_DN;
    endcase
    return c;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_prog_nxt  = r_prog;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (go && !stop) begin
          w_state_nxt = ST_RUN;
          w_step_nxt  = 2'd0;
          w_prog_nxt  = prog;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_step_nxt  = 2'd0;
        end else if (w_tc) begin
          if (r_step == 2'(NUM_STEPS - 1)) begin
            w_step_nxt = 2'd0;
            w_done_nxt = 1'b1;
`ifdef ACTION_REPEAT_EN
            w_state_nxt = ST_RUN;
`else
            w_state_nxt = ST_FINISH;
`endif
          end else begin
            w_step_nxt = r_step + 2'd1;
          end
        end
      end
      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_step_nxt  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_step  <= 2'd0;
      r_prog  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_prog  <= w_prog_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Decode from registered state so reset forces outputs without a clock.
  always_comb begin
    action = ACT_NOTHING;
    if (w_run) begin
      action = step_code(r_prog, r_step);
    end
  end

  assign busy = w_run;
  assign done = r_done;

endmodule

// File: tb/tb_action_sequencer.sv
// Self-checking bench for action_sequencer with DWELL=4.
// Build with ACTION_REPEAT_EN defined to check the looping variant.
module tb_action_sequencer;

  localparam int DW = 4;
  localparam logic [2:0] NOTH = 3'b110;
  localparam logic [2:0] UPC  = 3'b010;

  logic       clk;
  logic       rst_n;
  logic       go;
  logic       stop;
  logic       prog;
  logic [2:0] action;
  logic       busy;
  logic       done;

  typedef struct {
    logic       go;
    logic       stop;
    logic       prog;
    logic [2:0] act;
    logic       busy;
    logic       done;
  } vec_t;

  typedef struct {
    logic [2:0] act;
    logic       busy;
    logic       done;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks;
  int   errors;
  logic [2:0] seq1[4];
  logic [2:0] seq2[4];

  action_sequencer #(
    .DWELL(DW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (go),
    .stop   (stop),
    .prog   (prog),
    .action (action),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input exp_t e);
    checks++;
    if (action !== e.act || busy !== e.busy || done !== e.done) begin
      errors++;
      $display("FAIL %s: got act=%b busy=%b done=%b, want act=%b busy=%b done=%b",
               nm, action, busy, done, e.act, e.busy, e.done);
    end
  endtask

  function automatic void add(input logic g, input logic s, input logic p,
                              input logic [2:0] a, input logic b,
                              input logic d);
    vec_t v;
    v.go = g; v.stop = s; v.prog = p;
    v.act = a; v.busy = b; v.done = d;
    vecs.push_back(v);
  endfunction

  // One run from IDLE; stop_at>0 aborts in that run cycle.
  function automatic void build_run(input logic p, input bit tog,
                                    input int stop_at);
    int ncyc;
    bit rep;
    logic [2:0] c;
`ifdef ACTION_REPEAT_EN
    rep = 1'b1;
    ncyc = 40;
`else
    rep = 1'b0;
    ncyc = 16;
`endif
    add(1'b1, 1'b0, p, UPC, 1'b1, 1'b0);
    for (int k = 1; k < ncyc; k++) begin
      logic pk;
      pk = tog ? (p ^ logic'(k[0])) : p;
      if (k == stop_at) begin
        add(1'b0, 1'b1, pk, NOTH, 1'b0, 1'b0);
        add(1'b0, 1'b0, pk, NOTH, 1'b0, 1'b0);
        return;
      end
      c = p ? seq2[(k / DW) % 4] : seq1[(k / DW) % 4];
      add(k == 5, 1'b0, pk, c, 1'b1, rep && (k % 16 == 0));
    end
    if (rep) begin
      add(1'b0, 1'b1, 1'b0, NOTH, 1'b0, 1'b0);
    end else begin
      add(1'b1, 1'b0, 1'b0, NOTH, 1'b0, 1'b1);
    end
    add(1'b0, 1'b0, 1'b0, NOTH, 1'b0, 1'b0);
  endfunction

  task automatic apply_vecs(input string nm);
    exp_t e;
    foreach (vecs[i]) begin
      @(negedge clk);
      go   = vecs[i].go;
      stop = vecs[i].stop;
      prog = vecs[i].prog;
      e.act = vecs[i].act; e.busy = vecs[i].busy; e.done = vecs[i].done;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", nm, i), e);
    end
    vecs.delete();
    @(negedge clk);
    go = 1'b0; stop = 1'b0;
  endtask

  initial begin
    exp_t e;
    checks = 0;
    errors = 0;
    seq1 = '{3'b010, 3'b001, 3'b100, 3'b000};
    seq2 = '{3'b010, 3'b011, 3'b101, 3'b000};
    go = 1'b0; stop = 1'b0; prog = 1'b0;
    rst_n = 1'b0;
    #12;
    e = '{NOTH, 1'b0, 1'b0};
    check("reset", e);
    @(negedge clk);
    rst_n = 1'b1;

    build_run(1'b0, 1'b0, 0);
    apply_vecs("prog1");

    build_run(1'b1, 1'b1, 0);
    apply_vecs("prog2_toggle");

    build_run(1'b0, 1'b0, 6);
    apply_vecs("stop_c6");

    add(1'b1, 1'b1, 1'b0, NOTH, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, NOTH, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, NOTH, 1'b0, 1'b0);
    apply_vecs("go_stop_idle");

    // Reset pulsed mid-step, away from any clock edge.
    add(1'b1, 1'b0, 1'b1, UPC, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, UPC, 1'b1, 1'b0);
    apply_vecs("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    e = '{NOTH, 1'b0, 1'b0};
    check("async_rst", e);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      add(1'b0, 1'b0, 1'b0, NOTH, 1'b0, 1'b0);
    end
    apply_vecs("post_rst_idle");

    build_run(1'b1, 1'b0, 0);
    apply_vecs("restart_prog2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
